// File: rtl/sign_extend_pipe.sv
// Registered immediate extender with a 2-entry output buffer.
// Optional macro: SEXT_BRANCH_SHIFT_EN enables mode 11 branch-offset form.
module sign_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       mode_i,
   input  logic [IN_W-1:0]  data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [OUT_W-1:0] data_o,
   output logic             err_o
);

   localparam int PAD = OUT_W - IN_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [OUT_W-1:0] head;
   logic [OUT_W-1:0] tail;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] ext;
   logic             bad_mode;
   logic             push;
   logic             pop;

   assign sext = OUT_W'($signed(data_i));
   assign zext = OUT_W'(data_i);

   // Select the extension form; equal widths collapse to pass-through.
   always_comb begin
      ext      = sext;
      bad_mode = 1'b0;
      case (mode_i)
         2'b00: ext = sext;
         2'b01: ext = zext;
         2'b10: ext = zext << PAD;
         default: begin
`ifdef SEXT_BRANCH_SHIFT_EN
            ext = sext << 2;
`else
            ext      = sext;
            bad_mode = 1'b1;
`endif
         end
      endcase
      if (PAD == 0) ext = zext;
   end

   assign ready_o = (state != FULL) & rst_i;
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;
   assign data_o  = head;

   // Buffer occupancy FSM with registered head, tail and flags.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= EMPTY;
         head    <= '0;
         tail    <= '0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         if (push & bad_mode) err_o <= 1'b1;
         unique case (state)
            EMPTY: begin
               if (push) begin
                  head    <= ext;
                  valid_o <= 1'b1;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (push & pop) begin
                  head <= ext;
               end else if (push) begin
                  tail  <= ext;
                  state <= FULL;
               end else if (pop) begin
                  valid_o <= 1'b0;
                  state   <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head  <= tail;
                  state <= ONE;
               end
            end
            default: begin
               valid_o <= 1'b0;
               state   <= EMPTY;
            end
         endcase
      end
   end

endmodule
